adat_transmitter: RTL and testbench
===================================

// Module: adat_transmitter
// PURPOSE
//  Serialises 8 x 24-bit samples plus 4 user bits into one ADAT lightpipe frame per sample period.
//  Output is NRZI coded: 256 bits/frame at 256*fs.
//  Sits between the I2S-to-parallel deserialiser and adat_out_1_o/adat_out_2_o. Instantiated twice (ch 1-8, 9-16).
// PARAMETERS
//  CLK_DIV   2   clk_i cycles per ADAT bit (2 -> 12.288 Mbit/s from 24.576 MHz); legal 1..15
// PORTS
//  clk_i            in   1    sel_clk (512*fs); single clock domain
//  rst_i            in   1    synchronous, active-high reset
//  en_i             in   1    run request; sampled at frame boundaries only
//  sample_data_i    in   192  ch0 in [23:0] .. ch7 in [191:168], MSB first on the wire
//  user_i           in   4    user bits U3..U0, captured with sample_data_i
//  sample_valid_i   in   1    holding-register write request
//  sample_ready_o   out  1    holding register can accept
//  adat_o           out  1    NRZI serial output
//  frame_start_o    out  1    1-cycle pulse on the clk_i where bit 0 of a frame is launched
//  underrun_o       out  1    1-cycle pulse: frame launched with holding register empty
//  running_o        out  1    high while frames are being emitted
// BEHAVIOUR
//  Reset: adat_o=0, frame_start_o=0, underrun_o=0, running_o=0, sample_ready_o=1.
//   Holding register is empty; bit counter=0; divider=0; state=IDLE.
//  Bit tick: divider counts 0..CLK_DIV-1 while running; tick at 0. Each tick launches one frame bit.
//  Frame layout, bits 0..255:
//   - bits 0-9 = 0 (sync);
//   - bit 10 = 1;
//   - bits 11-14 = U3..U0;
//   - then 49 groups of "1 + nibble" are NOT used.
//   - Exact layout: every 4-bit group is FOLLOWED by a 1: bit 15=1; bits 16.. = ch0[23:20],1,ch0[19:16],1,..,ch7[3:0],1.
//   - bit 255 = 1. 10+1+49*5 = 256.
//  NRZI: on each tick, adat_o toggles if the frame bit is 1; otherwise it holds.
//  FSM:
//   - IDLE: adat_o held; no ticks. Leaves when en_i=1. Next clk_i is bit 0 of a new frame (divider=0).
//   - SYNC: bits 0-10.
//   - USER: bits 11-15.
//   - DATA: bits 16-255.
//   - After bit 255: if en_i=1, go to SYNC (back-to-back frames, no gap). If en_i=0, go to IDLE.
//   - en_i deasserted mid-frame: the current frame completes unchanged.
//  Frame load (cycle of the bit-0 tick):
//   - The 196-bit frame register takes the holding register's pre-cycle contents.
//   - The holding register is marked empty. frame_start_o=1.
//   - If the holding register was empty: underrun_o=1 and the frame content is per CONFIGURATION.
//  Holding register handshake:
//   - sample_ready_o = !full | load_now. A write occurs when sample_valid_i & sample_ready_o.
//   - Write and load in the same cycle: the load takes the old contents and the holding register takes the new data (stays full).
//   - Holding register full and not loading: sample_ready_o=0. New data must wait; nothing is overwritten.
//   - Writes are accepted in IDLE as well.
//  Latency: a sample accepted before a frame's bit-0 tick goes out in that frame. Its first data bit is on the wire 16*CLK_DIV cycles after frame_start_o.
//  running_o = (state != IDLE), registered.
//  rst_i mid-frame: aborts at once. adat_o=0 on the next cycle. Holding data is discarded.
// CONFIGURATION
//  ADAT_TX_HOLD_LAST_EN
//   - Defined: on underrun, the frame repeats the previously transmitted samples and user bits (zeros after reset).
//   - Undefined: on underrun, all 192 sample bits and user bits are sent as 0 (mute). Sync and separator 1s are unchanged.
//   - underrun_o pulses in both cases.
// STRUCTURE
//  adat_pkg (shared with the ADAT receiver):
//   - FRAME_BITS=256, SYNC_ZEROS=10, NCH=8, SAMPLE_W=24, USER_W=4;
//   - typedef enum {IDLE,SYNC,USER,DATA} adat_tx_state_t;
//   - typedef logic [NCH*SAMPLE_W-1:0] adat_samples_t.
//  Sub-module adat_nrzi_enc:
//   - inputs: clk_i, rst_i, tick, bit;
//   - output: registered NRZI line.
//   - Reused by loopback and test paths.
//  Frame bit selection: counter-driven 256-bit lookup or shift register; both meet the spec.
// TESTING
//  T1 reset:
//   - hold rst_i 3 cycles with en_i=1 -> all outputs at reset values; adat_o flat while rst_i=1.
//  T2 golden frame:
//   - CLK_DIV=2; ch0=24'hABCDEF, ch1..7=0, user=4'hA; en_i=1.
//   - A bench NRZI decoder sees 10 zeros, then 1, 1010, 1, 1010,1,1011,1,1100,1,1101,1,1110,1,1111,1, then 42x"00001".
//   - frame_start_o period is 512 cycles.
//  T3 underrun:
//   - no write before the 2nd frame -> underrun_o pulses with frame_start_o.
//   - Payload is all zeros (macro off) or a copy of frame 1 (macro on).
//  T4 handshake collision:
//   - holding full, sample_valid_i asserted on the load cycle -> sample_ready_o=1 that cycle.
//   - Frame N carries the old data; frame N+1 carries the new data; no underrun.
//  T5 stop mid-frame:
//   - en_i=0 at bit 100 -> frame completes all 256 bits, then running_o=0 and adat_o is stable.
//   - Restart with en_i=1 -> frame_start_o on the next cycle.
//  T6 backpressure and CLK_DIV=1:
//   - valid held high continuously -> exactly one write accepted per frame.
//   - Frame length is 256 cycles; no write is lost.

Source files
------------

// File: rtl/adat_pkg.sv
// adat_pkg: frame geometry and types shared by the ADAT transmitter and receiver.
package adat_pkg;
  localparam int FRAME_BITS = 256;
  localparam int SYNC_ZEROS = 10;
  localparam int NCH        = 8;
  localparam int SAMPLE_W   = 24;
  localparam int USER_W     = 4;
  // user nibble plus all sample bits, in wire order
  localparam int PAYLOAD_W  = NCH * SAMPLE_W + USER_W;

  typedef enum logic [1:0] {IDLE, SYNC, USER, DATA} adat_tx_state_t;
  typedef logic [NCH*SAMPLE_W-1:0] adat_samples_t;
  typedef logic [PAYLOAD_W-1:0]    adat_payload_t;

  // Reorder to wire order, MSB first: U3..U0, ch0[23:0], ch1[23:0] .. ch7[23:0].
  function automatic adat_payload_t adat_pack(input adat_samples_t s,
                                              input logic [USER_W-1:0] u);
    adat_payload_t p;
    p[PAYLOAD_W-1 -: USER_W] = u;
    for (int c = 0; c < NCH; c++)
      p[NCH*SAMPLE_W-1 - c*SAMPLE_W -: SAMPLE_W] = s[c*SAMPLE_W +: SAMPLE_W];
    return p;
  endfunction
endpackage

// File: rtl/adat_nrzi_enc.sv
// adat_nrzi_enc: NRZI line coder; the line toggles on every tick that carries a 1.
module adat_nrzi_enc (
  input  logic clk_i,
  input  logic rst_i,
  input  logic tick,
  input  logic line_bit,
  output logic line
);
  // toggle-on-one line register, forced low by reset
  always_ff @(posedge clk_i) begin
    if (rst_i)                line <= 1'b0;
    else if (tick && line_bit) line <= ~line;
  end
endmodule

// File: rtl/adat_transmitter.sv
// adat_transmitter: serialises 8 x 24-bit samples + 4 user bits into 256-bit NRZI ADAT frames.
// Optional build macro ADAT_TX_HOLD_LAST_EN: on underrun repeat the previous payload
// instead of muting it.
module adat_transmitter
  import adat_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [191:0] sample_data_i,
  input  logic [3:0]   user_i,
  input  logic         sample_valid_i,
  output logic         sample_ready_o,
  output logic         adat_o,
  output logic         frame_start_o,
  output logic         underrun_o,
  output logic         running_o
);
  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [7:0] SYNC_END = 8'(SYNC_ZEROS);               // the lone 1 after the sync zeros
  localparam logic [7:0] USER_END = 8'(SYNC_ZEROS + 1 + USER_W);  // separator after the user nibble
  localparam logic [7:0] LAST_BIT = 8'(FRAME_BITS - 1);

  adat_tx_state_t state, state_nx;
  logic [3:0]     div;
  logic [7:0]     bitcnt;
  logic [2:0]     ph;        // position inside a 4-bit + separator group
  adat_payload_t  hold, shreg, fill;
  logic           full, active, tick, bit_end, load, wr, in_groups, shift, line_bit;

  assign active    = (state != IDLE);
  assign tick      = active && (div == 4'd0);
  assign bit_end   = active && (div == DIV_LAST);
  assign load      = tick && (bitcnt == 8'd0);
  assign in_groups = (bitcnt > SYNC_END);
  assign shift     = bit_end && in_groups && (ph != 3'd4);

  assign sample_ready_o = !full || load;
  assign wr             = sample_valid_i && sample_ready_o;
  assign frame_start_o  = load;
  assign underrun_o     = load && !full;

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // next state; en_i only matters in IDLE and at the very end of a frame
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (en_i) state_nx = SYNC;
      SYNC:    if (bit_end && bitcnt == SYNC_END) state_nx = USER;
      USER:    if (bit_end && bitcnt == USER_END) state_nx = DATA;
      DATA:    if (bit_end && bitcnt == LAST_BIT) state_nx = en_i ? SYNC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // running flag mirrors the state register
  always_ff @(posedge clk_i) begin
    if (rst_i) running_o <= 1'b0;
    else       running_o <= (state_nx != IDLE);
  end

  // bit-rate divider, bit counter and group phase; all parked at 0 while idle
  always_ff @(posedge clk_i) begin
    if (rst_i || !active) begin
      div    <= 4'd0;
      bitcnt <= 8'd0;
      ph     <= 3'd0;
    end else if (bit_end) begin
      div    <= 4'd0;
      bitcnt <= bitcnt + 8'd1;               // wraps to 0 after the last bit
      if (in_groups) ph <= (ph == 3'd4) ? 3'd0 : ph + 3'd1;
    end else begin
      div <= div + 4'd1;
    end
  end

  // holding register: a same-cycle write and load leaves it full with the new data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full <= 1'b0;
    end else if (wr) begin
      hold <= adat_pack(sample_data_i, user_i);
      full <= 1'b1;
    end else if (load) begin
      full <= 1'b0;
    end
  end

`ifdef ADAT_TX_HOLD_LAST_EN
  adat_payload_t last;
  // copy of the most recently transmitted payload, replayed on underrun
  always_ff @(posedge clk_i) begin
    if (rst_i)             last <= '0;
    else if (load && full) last <= hold;
  end
  assign fill = last;
`else
  assign fill = '0;
`endif

  // frame shift register: loaded on the bit-0 tick, shifted after each payload bit
  always_ff @(posedge clk_i) begin
    if (rst_i)      shreg <= '0;
    else if (load)  shreg <= full ? hold : fill;
    else if (shift) shreg <= shreg << 1;
  end

  // frame bit: sync zeros, a 1, then payload nibbles each followed by a 1
  always_comb begin
    line_bit = 1'b0;
    if (bitcnt == SYNC_END) line_bit = 1'b1;
    else if (in_groups)     line_bit = (ph == 3'd4) ? 1'b1 : shreg[PAYLOAD_W-1];
  end

  adat_nrzi_enc u_nrzi (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tick     (tick),
    .line_bit (line_bit),
    .line     (adat_o)
  );
endmodule

// File: tb/tb_adat_transmitter.sv
// tb_adat_transmitter: two transmitters (CLK_DIV=2 and CLK_DIV=1) checked every cycle
// against a frame-level model, plus directed literal checks of frame content and timing.
module tb_adat_transmitter;
  localparam int DV0 = 2, DV1 = 1;

  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] en, valid, ready, adat, fs, ur, run;
  logic [1:0][191:0] sdata;
  logic [1:0][3:0]   user;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  adat_transmitter #(.CLK_DIV(DV0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .en_i(en[0]), .sample_data_i(sdata[0]), .user_i(user[0]),
    .sample_valid_i(valid[0]), .sample_ready_o(ready[0]), .adat_o(adat[0]),
    .frame_start_o(fs[0]), .underrun_o(ur[0]), .running_o(run[0]));

  adat_transmitter #(.CLK_DIV(DV1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .en_i(en[1]), .sample_data_i(sdata[1]), .user_i(user[1]),
    .sample_valid_i(valid[1]), .sample_ready_o(ready[1]), .adat_o(adat[1]),
    .frame_start_o(fs[1]), .underrun_o(ur[1]), .running_o(run[1]));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // frame bit k from the layout rules: 10 zeros, a 1, then 49 groups of nibble + 1
  function automatic logic fbit(input logic [191:0] s, input logic [3:0] u, input int k);
    int j, g, r, c, n;
    if (k < 10)  return 1'b0;
    if (k == 10) return 1'b1;
    j = k - 11; g = j / 5; r = j % 5;
    if (r == 4)  return 1'b1;
    if (g == 0)  return u[3-r];
    c = (g - 1) / 6; n = (g - 1) % 6;
    return s[c*24 + 23 - 4*n - r];
  endfunction

  function automatic logic [255:0] exp_frame(input logic [191:0] s, input logic [3:0] u);
    logic [255:0] v;
    for (int k = 0; k < 256; k++) v[k] = fbit(s, u, k);
    return v;
  endfunction

  function automatic logic [191:0] pat(input int s);
    logic [191:0] p;
    for (int c = 0; c < 8; c++) p[c*24 +: 24] = 24'(s * 7919 + c * 4099 + 24'h00A5A5);
    return p;
  endfunction

  // ---------------- model: position within frame, holding slot, line level ----------------
  bit           m_run [2], m_full [2], m_line [2];
  int           m_pos [2];
  logic [191:0] m_hs [2], m_cs [2], m_ls [2];
  logic [3:0]   m_hu [2], m_cu [2], m_lu [2];

  always @(posedge clk) begin
    bit fsm, wrm;
    int dv;
    for (int i = 0; i < 2; i++) begin
      dv = (i == 0) ? DV0 : DV1;
      if (rst) begin
        m_run[i] = 0; m_pos[i] = 0; m_full[i] = 0; m_line[i] = 0;
        m_cs[i] = '0; m_cu[i] = '0; m_ls[i] = '0; m_lu[i] = '0;
      end else begin
        fsm = m_run[i] && (m_pos[i] == 0);
        wrm = valid[i] && (!m_full[i] || fsm);
        if (fsm) begin
          if (m_full[i]) begin
            m_cs[i] = m_hs[i]; m_cu[i] = m_hu[i];
          end else begin
`ifdef ADAT_TX_HOLD_LAST_EN
            m_cs[i] = m_ls[i]; m_cu[i] = m_lu[i];
`else
            m_cs[i] = '0; m_cu[i] = '0;
`endif
          end
          m_ls[i] = m_cs[i]; m_lu[i] = m_cu[i];
        end
        if (wrm) begin
          m_hs[i] = sdata[i]; m_hu[i] = user[i]; m_full[i] = 1;
        end else if (fsm) begin
          m_full[i] = 0;
        end
        if (m_run[i]) begin
          if (m_pos[i] % dv == 0) m_line[i] = m_line[i] ^ fbit(m_cs[i], m_cu[i], m_pos[i] / dv);
          m_pos[i]++;
          if (m_pos[i] == 256 * dv) begin
            m_pos[i] = 0; m_run[i] = en[i];
          end
        end else if (en[i]) begin
          m_run[i] = 1; m_pos[i] = 0;
        end
      end
    end
  end

  // every-cycle comparison of all outputs of both instances
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("d%0d running_o", i), run[i], m_run[i]);
        check($sformatf("d%0d frame_start_o", i), fs[i], m_run[i] && m_pos[i] == 0);
        check($sformatf("d%0d underrun_o", i), ur[i], m_run[i] && m_pos[i] == 0 && !m_full[i]);
        check($sformatf("d%0d sample_ready_o", i), ready[i], !m_full[i] || (m_run[i] && m_pos[i] == 0));
        check($sformatf("d%0d adat_o", i), adat[i], m_line[i]);
      end
    end
  end

  task automatic wait_fs(input int i);
    int n = 0;
    while (!fs[i] && n < 3000) begin @(negedge clk); n++; end
    check($sformatf("d%0d frame_start seen", i), fs[i], 1'b1);
  endtask

  // NRZI-decode one frame starting at the current (frame start) negedge
  task automatic capture(input int i, input int dv, output logic [255:0] bits);
    logic cap [0:512];
    cap[0] = adat[i];
    for (int t = 1; t <= 256 * dv; t++) begin @(negedge clk); cap[t] = adat[i]; end
    for (int k = 0; k < 256; k++)
      bits[k] = ((k == 0) ? cap[0] : cap[(k-1)*dv + 1]) ^ cap[k*dv + 1];
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] got, lit, ev;
    logic [45:0]  head;
    logic [191:0] sg, sa, sb;
    int n, seq, nfs, wrs, cyc, it;
    bit pend;

    en = 2'b11; valid = 2'b00; sdata = '0; user = '0;
    @(posedge clk); chk_en = 1'b1;
    repeat (3) @(negedge clk);

    // T1: reset values with en_i high
    for (int i = 0; i < 2; i++) begin
      check("t1 sample_ready_o", ready[i], 1'b1);
      check("t1 adat_o", adat[i], 1'b0);
      check("t1 frame_start_o", fs[i], 1'b0);
      check("t1 underrun_o", ur[i], 1'b0);
      check("t1 running_o", run[i], 1'b0);
    end
    rst = 1'b0; en = 2'b00;

    // T2: golden frame
    sg = '0; sg[23:0] = 24'hABCDEF;
    sdata[0] = sg; user[0] = 4'hA; valid[0] = 1'b1;
    @(negedge clk); valid[0] = 1'b0; en[0] = 1'b1;
    head = 46'b0000000000_1_1010_1_1010_1_1011_1_1100_1_1101_1_1110_1_1111_1;
    for (int k = 0; k < 256; k++) lit[k] = (k < 46) ? head[45-k] : ((k - 46) % 5 == 4);
    check("model vs golden literal", exp_frame(sg, 4'hA), lit);
    wait_fs(0);
    check("t2 no underrun", ur[0], 1'b0);
    capture(0, DV0, got);
    check("t2 golden frame", got, lit);
    check("t2 period 512", fs[0], 1'b1);

    // T3: no write before frame 2
    check("t3 underrun", ur[0], 1'b1);
    capture(0, DV0, got);
`ifdef ADAT_TX_HOLD_LAST_EN
    ev = lit;
`else
    for (int k = 0; k < 256; k++) ev[k] = (k == 10) || (k > 10 && (k - 11) % 5 == 4);
`endif
    check("t3 underrun payload", got, ev);

    // T4: write A during frame 3, offer B while full, B accepted on frame 4 load
    @(negedge clk);
    sa = {24'h7E5C3A, 24'hFFFFFF, 24'h123456, 24'h800000, 24'h000001, 24'hF0F0F0, 24'h0F0F0F, 24'h876543};
    sb = ~sa;
    sdata[0] = sa; user[0] = 4'h5; valid[0] = 1'b1;
    @(negedge clk);
    check("t4 full blocks", ready[0], 1'b0);
    sdata[0] = sb; user[0] = 4'h9;
    wait_fs(0);
    check("t4 ready on load", ready[0], 1'b1);
    check("t4 no underrun N", ur[0], 1'b0);
    fork
      capture(0, DV0, got);
      begin @(negedge clk); valid[0] = 1'b0; end
    join
    check("t4 frame N old data", got, exp_frame(sa, 4'h5));
    check("t4 no underrun N+1", ur[0], 1'b0);
    capture(0, DV0, got);
    check("t4 frame N+1 new data", got, exp_frame(sb, 4'h9));

    // T5: drop en_i around bit 100, frame must complete
    repeat (100 * DV0) @(negedge clk);
    en[0] = 1'b0;
    n = 100 * DV0;
    while (run[0] && n < 1000) begin @(negedge clk); n++; end
    check("t5 stop after full frame", n, 512);
    repeat (10) @(negedge clk);
    en[0] = 1'b1;
    @(negedge clk);
    check("t5 restart frame_start", fs[0], 1'b1);

    // reset mid-frame
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid-frame adat_o", adat[0], 1'b0);
    check("rst mid-frame running_o", run[0], 1'b0);
    rst = 1'b0; en[0] = 1'b0;
    @(negedge clk);

    // T6: CLK_DIV=1, valid held high
    seq = 0; nfs = 0; wrs = 0; cyc = 0; it = 0; pend = 0;
    sdata[1] = pat(0); user[1] = 4'h0; valid[1] = 1'b1; en[1] = 1'b1;
    while (nfs < 6 && it < 3000) begin
      if (fs[1]) begin
        if (nfs >= 1) begin
          check("t6 writes per frame", wrs, 1);
          check("t6 frame length", cyc, 256);
        end
        nfs++; wrs = 0; cyc = 0;
      end
      if (ready[1]) begin wrs++; pend = 1; end
      @(negedge clk); cyc++; it++;
      if (pend) begin seq++; sdata[1] = pat(seq); user[1] = 4'(seq); pend = 0; end
    end
    check("t6 frames seen", nfs, 6);
    en[1] = 1'b0; valid[1] = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
